// File: rtl/fifo_rptr_empty_if.sv
// Read-side handshake and status bundle of the async FIFO pointer/status stage.
interface fifo_rptr_empty_if #(
  parameter int unsigned ASIZE = 4
);
  logic             rinc;
  logic [ASIZE:0]   rq2_wptr;
  logic             runderflow_clr;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0]   rptr;
  logic             rempty;
  logic             ralmost_empty;
  logic [ASIZE:0]   rlevel;
  logic             runderflow;

  modport master (
    output rinc, rq2_wptr, runderflow_clr,
    input  raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr, runderflow_clr,
    output raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
  );
endinterface

// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer/status stage: binary+Gray read pointer, registered empty,
// almost-empty, fill level and sticky underflow, all clocked by rclk.
module fifo_rptr_empty #(
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned AE_THRESH = 2
) (
  input logic              rclk,
  input logic              rrst_n,
  fifo_rptr_empty_if.slave rif
);
  localparam int unsigned PW = ASIZE + 1;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic [PW-1:0] wbin_c;
  logic          rempty_q, rempty_d;
  logic          ralmost_q, ralmost_d;
  logic          runder_q, runder_d;
  logic          pop_c;

  // Next pointer, level and flags are all derived from the post-pop pointer so
  // the flags change on the same edge the pointer advances.
  always_comb begin
    pop_c     = 1'b0;
    rbin_d    = rbin_q;
    rgray_d   = rgray_q;
    wbin_c    = '0;
    rlevel_d  = '0;
    rempty_d  = 1'b1;
    ralmost_d = 1'b1;
    runder_d  = runder_q;

    pop_c   = rif.rinc & ~rempty_q;
    rbin_d  = rbin_q + PW'(pop_c);
    rgray_d = (rbin_d >> 1) ^ rbin_d;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
    for (int unsigned i = 0; i < PW; i++) begin
      wbin_c[i] = ^(rif.rq2_wptr >> i);
    end

    rlevel_d  = wbin_c - rbin_d;
    rempty_d  = (rgray_d == rif.rq2_wptr);
    ralmost_d = (rlevel_d <= PW'(AE_THRESH));
    runder_d  = (rif.rinc & rempty_q) | (runder_q & ~rif.runderflow_clr);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rgray_q   <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      ralmost_q <= 1'b1;
      runder_q  <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rgray_q   <= rgray_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      ralmost_q <= ralmost_d;
      runder_q  <= runder_d;
    end
  end

  assign rif.raddr         = rbin_q[ASIZE-1:0];
  assign rif.rptr          = rgray_q;
  assign rif.rempty        = rempty_q;
  assign rif.ralmost_empty = ralmost_q;
  assign rif.rlevel        = rlevel_q;
  assign rif.runderflow    = runder_q;
endmodule
